// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: memory access size encodings and the
// load/store unit state type, used by the LSU and by control_logic.
package riscv_pkg;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_WORD = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } lsu_state_t;

    // Reserved size is reported through the same fault path as misalignment.
    function automatic logic is_misaligned(input logic [1:0] mode, input logic [1:0] addr_lo);
        case (mode)
            MODE_HALF: return addr_lo[0];
            MODE_WORD: return addr_lo != 2'b00;
            MODE_RSVD: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: byte enables and store replication on the
// way out, lane shift and sign/zero extension on the way back.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]  i_mode,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_load_unsigned,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);

    logic [31:0] w_shifted;

    assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        o_be        = 4'b0000;
        o_wdata     = 32'h0;
        o_load_data = 32'h0;
        case (i_mode)
            MODE_BYTE: begin
                o_be        = 4'b0001 << i_addr_lo;
                o_wdata     = {4{i_store_data[7:0]}};
                o_load_data = i_load_unsigned ? {24'h0, w_shifted[7:0]}
                                              : {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            MODE_HALF: begin
                o_be        = 4'b0011 << i_addr_lo;
                o_wdata     = {2{i_store_data[15:0]}};
                o_load_data = i_load_unsigned ? {16'h0, w_shifted[15:0]}
                                              : {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            MODE_WORD: begin
                o_be        = 4'b1111;
                o_wdata     = i_store_data;
                o_load_data = w_shifted;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory request from execute, runs a single
// data-bus transaction with timeout, and returns an extended load result.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        mem_write_i,
    input  logic [1:0]  mem_mode_i,
    input  logic        load_unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] load_data_o,
    output logic        misaligned_o,
    output logic        fault_o,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_ack_i,
    input  logic [31:0] dbus_rdata_i
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    lsu_state_t  r_state;
    lsu_state_t  w_next;
    logic [7:0]  r_cnt;
    logic        r_write;
    logic        r_unsigned;
    logic [1:0]  r_mode;
    logic [1:0]  r_addr_lo;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_load_data;
    logic        r_misaligned;
    logic        r_fault;

    logic        w_misaligned;
    logic        w_timeout;
    logic [1:0]  w_sel_mode;
    logic [1:0]  w_sel_addr_lo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;

    assign w_misaligned = is_misaligned(mem_mode_i, addr_i[1:0]);
    assign w_timeout    = (r_cnt == TIMEOUT_LAST);

    // One aligner serves both directions: live request fields while IDLE
    // (lane setup), captured fields afterwards (read data extraction).
    assign w_sel_mode    = (r_state == IDLE) ? mem_mode_i  : r_mode;
    assign w_sel_addr_lo = (r_state == IDLE) ? addr_i[1:0] : r_addr_lo;

    lsu_align u_align (
        .i_mode          (w_sel_mode),
        .i_addr_lo       (w_sel_addr_lo),
        .i_load_unsigned (r_unsigned),
        .i_store_data    (store_data_i),
        .i_rdata         (dbus_rdata_i),
        .o_be            (w_be),
        .o_wdata         (w_wdata),
        .o_load_data     (w_load_data)
    );

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start_i) w_next = w_misaligned ? DONE : ACCESS;
            ACCESS:  if (dbus_ack_i || w_timeout) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy_o       = (r_state != IDLE);
        done_o       = (r_state == DONE);
        misaligned_o = (r_state == DONE) && r_misaligned;
        fault_o      = (r_state == DONE) && r_fault;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt        <= 8'h0;
            r_write      <= 1'b0;
            r_unsigned   <= 1'b0;
            r_mode       <= MODE_BYTE;
            r_addr_lo    <= 2'b00;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= 32'h0;
            r_be         <= 4'h0;
            r_wdata      <= 32'h0;
            r_load_data  <= 32'h0;
            r_misaligned <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_write      <= mem_write_i;
                        r_unsigned   <= load_unsigned_i;
                        r_mode       <= mem_mode_i;
                        r_addr_lo    <= addr_i[1:0];
                        r_cnt        <= 8'h0;
                        r_fault      <= 1'b0;
                        r_misaligned <= w_misaligned;
                        if (w_misaligned) begin
                            r_load_data <= 32'h0;
                        end else begin
                            r_req   <= 1'b1;
                            r_we    <= mem_write_i;
                            r_addr  <= {addr_i[31:2], 2'b00};
                            r_be    <= w_be;
                            r_wdata <= w_wdata;
                        end
                    end
                end
                ACCESS: begin
                    // An ack on the final counted cycle takes priority over the timeout.
                    if (dbus_ack_i) begin
                        r_req       <= 1'b0;
                        r_we        <= 1'b0;
                        r_load_data <= r_write ? 32'h0 : w_load_data;
                    end else if (w_timeout) begin
                        r_req       <= 1'b0;
                        r_we        <= 1'b0;
                        r_fault     <= 1'b1;
                        r_load_data <= 32'h0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbus_req_o   = r_req;
    assign dbus_we_o    = r_we;
    assign dbus_addr_o  = r_addr;
    assign dbus_be_o    = r_be;
    assign dbus_wdata_o = r_wdata;
    assign load_data_o  = r_load_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed corner cases followed by
// randomized requests compared against a byte-lane reference model.
module tb_load_store_unit;

    localparam int TMO = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        mem_write_i = 1'b0;
    logic [1:0]  mem_mode_i = 2'b00;
    logic        load_unsigned_i = 1'b0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] store_data_i = 32'h0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] load_data_o;
    logic        misaligned_o;
    logic        fault_o;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_ack_i = 1'b0;
    logic [31:0] dbus_rdata_i = 32'h0;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_load = 32'h0;

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .start_i         (start_i),
        .mem_write_i     (mem_write_i),
        .mem_mode_i      (mem_mode_i),
        .load_unsigned_i (load_unsigned_i),
        .addr_i          (addr_i),
        .store_data_i    (store_data_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .load_data_o     (load_data_o),
        .misaligned_o    (misaligned_o),
        .fault_o         (fault_o),
        .dbus_req_o      (dbus_req_o),
        .dbus_we_o       (dbus_we_o),
        .dbus_addr_o     (dbus_addr_o),
        .dbus_be_o       (dbus_be_o),
        .dbus_wdata_o    (dbus_wdata_o),
        .dbus_ack_i      (dbus_ack_i),
        .dbus_rdata_i    (dbus_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Reference model: sizes in bytes, lane arithmetic on whole words.
    function automatic bit ref_misaligned(input logic [1:0] mode, input logic [31:0] addr);
        int sz;
        if (mode == 2'd3) return 1'b1;
        sz = 1 << mode;
        return (addr % sz) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] mode, input logic [31:0] addr);
        int sz;
        int m;
        sz = 1 << mode;
        m  = ((1 << sz) - 1) << (addr % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] mode, input logic [31:0] data);
        int sz;
        logic [31:0] w;
        sz = 1 << mode;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = data[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] mode, input logic uns,
                                             input logic [31:0] addr, input logic [31:0] rdata);
        int sz;
        logic [31:0] v;
        logic [31:0] mask;
        sz   = 1 << mode;
        v    = rdata >> (8 * (addr % 4));
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
        v    = v & mask;
        if (!uns && sz < 4 && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // ack_at: ACCESS cycle index (0 = first) in which the bus acks; >= TMO means never.
    task automatic run_op(input logic wr, input logic [1:0] mode, input logic uns,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] rdata, input int ack_at);
        bit          mis;
        bit          acked;
        logic [31:0] exp_ld;
        mis   = ref_misaligned(mode, addr);
        acked = 1'b0;
        mem_write_i     = wr;
        mem_mode_i      = mode;
        load_unsigned_i = uns;
        addr_i          = addr;
        store_data_i    = data;
        start_i         = 1'b1;
        step();
        start_i = 1'b0;
        check1("busy_after_start", busy_o, 1'b1);
        if (mis) begin
            check1("mis_no_req", dbus_req_o, 1'b0);
            check1("mis_done", done_o, 1'b1);
            check1("mis_flag", misaligned_o, 1'b1);
            check1("mis_no_fault", fault_o, 1'b0);
            check32("mis_load_data", load_data_o, 32'h0);
            exp_ld = 32'h0;
        end else begin
            check1("dbus_we", dbus_we_o, wr);
            check32("dbus_addr", dbus_addr_o, {addr[31:2], 2'b00});
            check32("dbus_be", {28'h0, dbus_be_o}, {28'h0, ref_be(mode, addr)});
            if (wr) check32("dbus_wdata", dbus_wdata_o, ref_wdata(mode, data));
            for (int k = 0; k < TMO; k++) begin
                check1("req_in_access", dbus_req_o, 1'b1);
                check1("no_done_in_access", done_o, 1'b0);
                if (k == ack_at) begin
                    dbus_ack_i   = 1'b1;
                    dbus_rdata_i = rdata;
                end
                step();
                dbus_ack_i   = 1'b0;
                dbus_rdata_i = $urandom;
                if (k == ack_at) begin
                    acked = 1'b1;
                    break;
                end
            end
            exp_ld = (acked && !wr) ? ref_load(mode, uns, addr, rdata) : 32'h0;
            check1("done_pulse", done_o, 1'b1);
            check1("fault_flag", fault_o, !acked);
            check1("no_misaligned", misaligned_o, 1'b0);
            check1("req_dropped", dbus_req_o, 1'b0);
            check32("load_data", load_data_o, exp_ld);
        end
        last_load = exp_ld;
        step();
        check1("done_one_cycle", done_o, 1'b0);
        check1("idle_after_done", busy_o, 1'b0);
        check32("load_data_held", load_data_o, last_load);
    endtask

    int          dones;
    int          reqs;
    logic        prev_done;
    logic        prev_req;
    logic        r_wr;
    logic [1:0]  r_mode;
    logic [31:0] r_addr;

    initial begin
        // Reset values
        #2;
        check1("rst_busy", busy_o, 1'b0);
        check1("rst_done", done_o, 1'b0);
        check1("rst_req", dbus_req_o, 1'b0);
        check1("rst_we", dbus_we_o, 1'b0);
        check32("rst_addr", dbus_addr_o, 32'h0);
        check32("rst_be", {28'h0, dbus_be_o}, 32'h0);
        check32("rst_wdata", dbus_wdata_o, 32'h0);
        check32("rst_load", load_data_o, 32'h0);
        step();
        step();
        rst_ni = 1'b1;
        step();

        // Signed byte load from lane 3; done in the third cycle counting the start cycle
        run_op(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 0);
        check32("lb_signed_result", last_load, 32'hFFFF_FF80);

        // Half store to upper lanes
        run_op(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 0);

        // Misaligned word load
        run_op(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 32'h0, 0);

        // Timeout: bus never acks
        run_op(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 32'h0, TMO);

        // Ack in the last counted cycle wins over the timeout
        run_op(1'b0, 2'b10, 1'b0, 32'h0000_4004, 32'h0, 32'hCAFE_F00D, TMO - 1);

        // Asynchronous reset in the second ACCESS cycle
        mem_write_i = 1'b0;
        mem_mode_i  = 2'b10;
        addr_i      = 32'h0000_0040;
        start_i     = 1'b1;
        step();
        start_i = 1'b0;
        check1("pre_rst_req_c1", dbus_req_o, 1'b1);
        step();
        check1("pre_rst_req_c2", dbus_req_o, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        check1("rst_mid_req", dbus_req_o, 1'b0);
        check1("rst_mid_busy", busy_o, 1'b0);
        check1("rst_mid_done", done_o, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check1("rst_hold_no_done", done_o, 1'b0);
        end
        rst_ni = 1'b1;
        step();
        check1("post_rst_no_done", done_o, 1'b0);
        run_op(1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0, 32'h0000_F00D, 0);

        // start_i held high: one operation per IDLE visit
        mem_write_i     = 1'b0;
        mem_mode_i      = 2'b10;
        load_unsigned_i = 1'b0;
        addr_i          = 32'h0000_0100;
        dbus_ack_i      = 1'b1;
        dbus_rdata_i    = 32'h1234_5678;
        start_i         = 1'b1;
        dones     = 0;
        reqs      = 0;
        prev_done = 1'b0;
        prev_req  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            check1("no_back_to_back_done", done_o & prev_done, 1'b0);
            if (done_o) dones++;
            if (dbus_req_o && !prev_req) reqs++;
            prev_done = done_o;
            prev_req  = dbus_req_o;
        end
        start_i    = 1'b0;
        dbus_ack_i = 1'b0;
        check32("held_start_ops", 32'(dones), 32'd4);
        check32("held_start_reqs", 32'(reqs), 32'd4);
        check32("held_start_load", load_data_o, 32'h1234_5678);
        step();
        check1("held_start_idle", busy_o, 1'b0);

        // Randomized requests
        for (int n = 0; n < 40; n++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_mode = 2'($urandom_range(0, 3));
            r_addr = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                if (r_mode == 2'b01) r_addr[0] = 1'b0;
                if (r_mode == 2'b10) r_addr[1:0] = 2'b00;
            end
            run_op(r_wr, r_mode, 1'($urandom_range(0, 1)), r_addr, $urandom, $urandom,
                   int'($urandom_range(0, TMO)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
